bp_fe_lce_data_cmd_tx: RTL and testbench

Transmit side of the CCE/LCE data-command channel for the front-end I-cache LCE. It services LCE-to-LCE transfer requests raised by the LCE command handler: it reads the victim line from the I-cache data memory through a data-mem read packet, then emits one `bp_cce_lce_data_cmd_s` beat (msg type transfer) toward the destination LCE with a valid/ready handshake. It sits beside the LCE data-command receiver and shares the `bp_fe_icache_lce_data_mem_pkt_s` format and arbiter port with it.

---
 rtl/bp_fe_lce_data_cmd_tx_if.sv | 63 ++++++
 rtl/bp_fe_lce_data_cmd_tx.sv | 150 +++++++++++++++
 tb/tb_bp_fe_lce_data_cmd_tx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_lce_data_cmd_tx_if.sv
// Bundles the three channels around the I-cache LCE data-command transmitter.
//
// Signals:
//   tr_*            transfer request from the LCE command handler (valid/ready)
//                   plus tr_done_o, a one-cycle completion pulse
//   data_mem_pkt_*  read packet toward the I-cache data memory (valid/yumi)
//   data_mem_data_i line returned by the data memory the cycle after yumi
//   lce_data_cmd_*  outgoing data command toward the destination LCE (valid/ready)
//
// Modports:
//   master  the transmitter's view (drives tr_ready_o, packet, command, done)
//   slave   the surrounding logic's view
interface bp_fe_lce_data_cmd_tx_if #(
    parameter int unsigned lce_addr_width_p = 22,
    parameter int unsigned lce_data_width_p = 512,
    parameter int unsigned num_lce_p        = 2,
    parameter int unsigned lce_sets_p       = 64,
    parameter int unsigned ways_p           = 8
);
    localparam int unsigned lg_num_lce_lp  = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int unsigned lg_ways_lp     = (ways_p > 1) ? $clog2(ways_p) : 1;
    localparam int unsigned lg_lce_sets_lp = (lce_sets_p > 1) ? $clog2(lce_sets_p) : 1;
    // {index, way_id, data, we}
    localparam int unsigned pkt_width_lp   = lg_lce_sets_lp + lg_ways_lp + lce_data_width_p + 1;
    // {dst_id, msg_type, way_id, addr, data}
    localparam int unsigned cmd_width_lp   = lg_num_lce_lp + 1 + lg_ways_lp + lce_addr_width_p
                                             + lce_data_width_p;

    logic                        tr_v_i;
    logic                        tr_ready_o;
    logic [lg_num_lce_lp-1:0]    tr_dst_id_i;
    logic [lg_ways_lp-1:0]       tr_src_way_i;
    logic [lg_ways_lp-1:0]       tr_dst_way_i;
    logic [lce_addr_width_p-1:0] tr_addr_i;
    logic                        tr_done_o;

    logic                        data_mem_pkt_v_o;
    logic [pkt_width_lp-1:0]     data_mem_pkt_o;
    logic                        data_mem_pkt_yumi_i;
    logic [lce_data_width_p-1:0] data_mem_data_i;

    logic                        lce_data_cmd_v_o;
    logic [cmd_width_lp-1:0]     lce_data_cmd_o;
    logic                        lce_data_cmd_ready_i;

    modport master (
        input  tr_v_i, tr_dst_id_i, tr_src_way_i, tr_dst_way_i, tr_addr_i,
        output tr_ready_o, tr_done_o,
        output data_mem_pkt_v_o, data_mem_pkt_o,
        input  data_mem_pkt_yumi_i, data_mem_data_i,
        output lce_data_cmd_v_o, lce_data_cmd_o,
        input  lce_data_cmd_ready_i
    );

    modport slave (
        output tr_v_i, tr_dst_id_i, tr_src_way_i, tr_dst_way_i, tr_addr_i,
        input  tr_ready_o, tr_done_o,
        input  data_mem_pkt_v_o, data_mem_pkt_o,
        output data_mem_pkt_yumi_i, data_mem_data_i,
        input  lce_data_cmd_v_o, lce_data_cmd_o,
        output lce_data_cmd_ready_i
    );
endinterface

// File: rtl/bp_fe_lce_data_cmd_tx.sv
// Transmit side of the front-end I-cache LCE data-command channel. Services one
// LCE-to-LCE transfer at a time: reads the victim line out of the I-cache data
// memory, then sends it to the destination LCE as a single transfer data command.
//
// Ports:
//   clk_i    clock
//   reset_i  asynchronous, active-high reset (returns to idle, drops all valids)
//   bus      bp_fe_lce_data_cmd_tx_if.master: transfer request/done, data-mem read
//            packet and returned line, outgoing data command
//
// Packed layouts (MSB first):
//   data-mem packet : {index, way_id, data, we}
//   data command    : {dst_id, msg_type, way_id, addr, data}, msg_type 1 = transfer
//
// Optional feature: define BP_FE_LCE_DATA_CMD_TX_CWF_EN for critical-word-first;
// the captured line is rotated so the addressed word lands in word 0.
module bp_fe_lce_data_cmd_tx #(
    parameter int unsigned data_width_p          = 64,
    parameter int unsigned lce_addr_width_p      = 22,
    parameter int unsigned lce_data_width_p      = 512,
    parameter int unsigned num_cce_p             = 1,
    parameter int unsigned num_lce_p             = 2,
    parameter int unsigned lce_sets_p            = 64,
    parameter int unsigned ways_p                = 8,
    parameter int unsigned block_size_in_bytes_p = 8
) (
    input logic                     clk_i,
    input logic                     reset_i,
    bp_fe_lce_data_cmd_tx_if.master bus
);
    localparam int unsigned data_mask_width_lp        = data_width_p >> 3;
    localparam int unsigned lg_data_mask_width_lp     = $clog2(data_mask_width_lp);
    localparam int unsigned lg_block_size_in_bytes_lp = $clog2(block_size_in_bytes_p);
    localparam int unsigned lg_lce_sets_lp = (lce_sets_p > 1) ? $clog2(lce_sets_p) : 1;
    localparam int unsigned lg_ways_lp     = (ways_p > 1) ? $clog2(ways_p) : 1;
    localparam int unsigned lg_num_lce_lp  = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;

    localparam logic e_lce_data_cmd_transfer = 1'b1;

    typedef struct packed {
        logic [lg_lce_sets_lp-1:0]   index;
        logic [lg_ways_lp-1:0]       way_id;
        logic [lce_data_width_p-1:0] data;
        logic                        we;
    } bp_fe_icache_lce_data_mem_pkt_s;

    typedef struct packed {
        logic [lg_num_lce_lp-1:0]    dst_id;
        logic                        msg_type;
        logic [lg_ways_lp-1:0]       way_id;
        logic [lce_addr_width_p-1:0] addr;
        logic [lce_data_width_p-1:0] data;
    } bp_cce_lce_data_cmd_s;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] SEND    = 2'd3;

    // num_cce_p only sizes CCE-side structures; nothing here depends on it.
    logic [31:0] unused_num_cce;
    assign unused_num_cce = num_cce_p;

    logic [1:0]                  state_q, state_d;
    logic [lg_num_lce_lp-1:0]    dst_id_q;
    logic [lg_ways_lp-1:0]       src_way_q;
    logic [lg_ways_lp-1:0]       dst_way_q;
    logic [lce_addr_width_p-1:0] addr_q;
    logic [lce_data_width_p-1:0] line_q, line_d;
    logic                        accept;

    bp_fe_icache_lce_data_mem_pkt_s pkt;
    bp_cce_lce_data_cmd_s           cmd;

    assign accept = (state_q == IDLE) & bus.tr_v_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.tr_v_i) state_d = RD_REQ;
            RD_REQ:  if (bus.data_mem_pkt_yumi_i) state_d = RD_WAIT;
            RD_WAIT: state_d = SEND;
            SEND:    if (bus.lce_data_cmd_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BP_FE_LCE_DATA_CMD_TX_CWF_EN
    logic [lg_block_size_in_bytes_lp-1:0] word_sel;
    int unsigned                          rot_amt;

    // Rotate right by whole words; a zero rotate makes the left shift clear to 0.
    always_comb begin
        word_sel = addr_q[lg_data_mask_width_lp +: lg_block_size_in_bytes_lp];
        rot_amt  = 32'(word_sel) * data_width_p;
        line_d   = (bus.data_mem_data_i >> rot_amt)
                 | (bus.data_mem_data_i << (lce_data_width_p - rot_amt));
    end
`else
    assign line_d = bus.data_mem_data_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            dst_id_q  <= '0;
            src_way_q <= '0;
            dst_way_q <= '0;
            addr_q    <= '0;
            line_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dst_id_q  <= bus.tr_dst_id_i;
                src_way_q <= bus.tr_src_way_i;
                dst_way_q <= bus.tr_dst_way_i;
                addr_q    <= bus.tr_addr_i;
            end
            // Memory returns data the cycle after yumi, which is always RD_WAIT.
            if (state_q == RD_WAIT) begin
                line_q <= line_d;
            end
        end
    end

    always_comb begin
        pkt        = '0;
        pkt.index  = addr_q[lg_data_mask_width_lp + lg_block_size_in_bytes_lp +: lg_lce_sets_lp];
        pkt.way_id = src_way_q;
        pkt.data   = '0;
        pkt.we     = 1'b0;
    end

    always_comb begin
        cmd          = '0;
        cmd.dst_id   = dst_id_q;
        cmd.msg_type = e_lce_data_cmd_transfer;
        cmd.way_id   = dst_way_q;
        cmd.addr     = addr_q;
        cmd.data     = line_q;
    end

    assign bus.tr_ready_o       = (state_q == IDLE);
    assign bus.data_mem_pkt_v_o = (state_q == RD_REQ);
    assign bus.data_mem_pkt_o   = pkt;
    assign bus.lce_data_cmd_v_o = (state_q == SEND);
    assign bus.lce_data_cmd_o   = cmd;
    assign bus.tr_done_o        = (state_q == SEND) & bus.lce_data_cmd_ready_i;

endmodule

// File: tb/tb_bp_fe_lce_data_cmd_tx.sv
// Self-checking bench for bp_fe_lce_data_cmd_tx. A behavioural memory of lines
// and a transfer-level model give the expected read packet, command and timing.
module tb_bp_fe_lce_data_cmd_tx;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 22;
    localparam int unsigned LDW   = 512;
    localparam int unsigned NLCE  = 2;
    localparam int unsigned SETS  = 64;
    localparam int unsigned WAYS  = 8;
    localparam int unsigned BSB   = 8;
    localparam int unsigned WORDS = LDW / DW;

    typedef struct packed {
        logic [0:0]    dst;
        logic [2:0]    sw;
        logic [2:0]    dw;
        logic [AW-1:0] addr;
    } req_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [LDW-1:0] mem [SETS][WAYS];
    logic [538:0]   last_cmd;

    bp_fe_lce_data_cmd_tx_if #(
        .lce_addr_width_p(AW), .lce_data_width_p(LDW), .num_lce_p(NLCE),
        .lce_sets_p(SETS), .ways_p(WAYS)
    ) bus ();

    bp_fe_lce_data_cmd_tx #(
        .data_width_p(DW), .lce_addr_width_p(AW), .lce_data_width_p(LDW), .num_cce_p(1),
        .num_lce_p(NLCE), .lce_sets_p(SETS), .ways_p(WAYS), .block_size_in_bytes_p(BSB)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.dst  = 1'($urandom);
        r.sw   = 3'($urandom);
        r.dw   = 3'($urandom);
        r.addr = AW'($urandom);
        return r;
    endfunction

    // Line index and word offset come straight from the byte address.
    function automatic int set_of(input req_t r);
        return (int'(r.addr) / (BSB * (DW / 8))) % SETS;
    endfunction

    function automatic logic [LDW-1:0] exp_data(input logic [LDW-1:0] line, input req_t r);
        logic [LDW-1:0] d;
        int w;
        w = (int'(r.addr) / (DW / 8)) % WORDS;
`ifdef BP_FE_LCE_DATA_CMD_TX_CWF_EN
        for (int k = 0; k < WORDS; k++) d[k*DW +: DW] = line[((k + w) % WORDS)*DW +: DW];
`else
        d = line;
        if (w < 0) d = '0;
`endif
        return d;
    endfunction

    task automatic drive_req(input bit v, input req_t r);
        bus.tr_v_i       = v;
        bus.tr_dst_id_i  = r.dst;
        bus.tr_src_way_i = r.sw;
        bus.tr_dst_way_i = r.dw;
        bus.tr_addr_i    = r.addr;
    endtask

    // While busy: either hold the next request, or throw random requests that must be ignored.
    task automatic busy_req(input bit nv, input req_t nr);
        if (nv) drive_req(1'b1, nr);
        else drive_req(1'($urandom), rand_req());
    endtask

    task automatic junk_data();
        bus.data_mem_data_i = {16{$urandom}};
    endtask

    task automatic run_transfer(input req_t r, input int ystall, input int rstall,
                                input bit nv, input req_t nr);
        logic [521:0] epkt;
        logic [538:0] ecmd;
        logic [LDW-1:0] line;
        line = mem[set_of(r)][r.sw];
        epkt = {6'(set_of(r)), r.sw, {LDW{1'b0}}, 1'b0};
        ecmd = {r.dst, 1'b1, r.dw, r.addr, exp_data(line, r)};

        check("idle_tr_ready", bus.tr_ready_o, 1'b1);
        check("idle_cmd_v", bus.lce_data_cmd_v_o, 1'b0);
        drive_req(1'b1, r);
        bus.data_mem_pkt_yumi_i  = 1'b0;
        bus.lce_data_cmd_ready_i = 1'b0;
        junk_data();
        @(negedge clk);

        for (int i = 0; i <= ystall; i++) begin
            check("rdreq_pkt_v", bus.data_mem_pkt_v_o, 1'b1);
            check("rdreq_pkt", bus.data_mem_pkt_o, epkt);
            check("rdreq_tr_ready", bus.tr_ready_o, 1'b0);
            check("rdreq_cmd_v", bus.lce_data_cmd_v_o, 1'b0);
            busy_req(nv, nr);
            bus.data_mem_pkt_yumi_i = (i == ystall);
            junk_data();
            @(negedge clk);
        end

        check("rdwait_pkt_v", bus.data_mem_pkt_v_o, 1'b0);
        check("rdwait_cmd_v", bus.lce_data_cmd_v_o, 1'b0);
        check("rdwait_tr_ready", bus.tr_ready_o, 1'b0);
        bus.data_mem_pkt_yumi_i = 1'b0;
        bus.data_mem_data_i     = line;
        busy_req(nv, nr);
        @(negedge clk);

        for (int j = 0; j <= rstall; j++) begin
            check("send_cmd_v", bus.lce_data_cmd_v_o, 1'b1);
            check("send_cmd", bus.lce_data_cmd_o, ecmd);
            check("send_tr_ready", bus.tr_ready_o, 1'b0);
            check("send_pkt_v", bus.data_mem_pkt_v_o, 1'b0);
            junk_data();
            if (j == rstall) drive_req(nv, nr);
            else busy_req(nv, nr);
            bus.lce_data_cmd_ready_i = (j == rstall);
            #1;
            check("send_done", bus.tr_done_o, (j == rstall));
            last_cmd = bus.lce_data_cmd_o;
            @(negedge clk);
        end

        bus.lce_data_cmd_ready_i = 1'b0;
        check("after_tr_ready", bus.tr_ready_o, 1'b1);
        check("after_cmd_v", bus.lce_data_cmd_v_o, 1'b0);
        check("after_done", bus.tr_done_o, 1'b0);
    endtask

    initial begin
        req_t r;
        req_t none;
        req_t reqs [9];
        bit   b2b [9];
        logic [LDW-1:0] line;

        checks = 0;
        errors = 0;
        none   = '0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                for (int k = 0; k < 16; k++) mem[s][w][k*32 +: 32] = $urandom;
        for (int k = 0; k < WORDS; k++) mem[7][3][k*DW +: DW] = 64'(k * 'h11);

        rst = 1'b1;
        drive_req(1'b0, none);
        bus.data_mem_pkt_yumi_i  = 1'b0;
        bus.lce_data_cmd_ready_i = 1'b0;
        bus.data_mem_data_i      = '0;
        #3;
        check("rst_tr_ready", bus.tr_ready_o, 1'b1);
        check("rst_pkt_v", bus.data_mem_pkt_v_o, 1'b0);
        check("rst_cmd_v", bus.lce_data_cmd_v_o, 1'b0);
        check("rst_done", bus.tr_done_o, 1'b0);
        check("rst_pkt", bus.data_mem_pkt_o, 522'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic directed transfer, then CWF word placement.
        r.dst = 1'b1; r.sw = 3'd3; r.dw = 3'd5; r.addr = AW'(22'h1C8);
        run_transfer(r, 0, 0, 1'b0, none);
`ifdef BP_FE_LCE_DATA_CMD_TX_CWF_EN
        check("cwf_word0", last_cmd[63:0], 64'h11);
        check("cwf_word7", last_cmd[511:448], 64'h00);
`else
        check("cwf_word0", last_cmd[63:0], 64'h00);
        check("cwf_word7", last_cmd[511:448], 64'h77);
`endif

        // Yumi stall, then ready backpressure.
        run_transfer(rand_req(), 4, 0, 1'b0, none);
        run_transfer(rand_req(), 0, 6, 1'b0, none);

        // Random transfers, some back-to-back with the next request held valid.
        for (int i = 0; i < 9; i++) begin
            reqs[i] = rand_req();
            b2b[i]  = 1'($urandom);
        end
        b2b[0] = 1'b1;
        for (int i = 0; i < 8; i++)
            run_transfer(reqs[i], $urandom_range(0, 3), $urandom_range(0, 3),
                         (i < 7) ? b2b[i] : 1'b0, reqs[i+1]);

        // Reset while in SEND.
        r = rand_req();
        line = mem[set_of(r)][r.sw];
        drive_req(1'b1, r);
        bus.data_mem_pkt_yumi_i = 1'b1;
        @(negedge clk);
        drive_req(1'b0, r);
        @(negedge clk);
        bus.data_mem_pkt_yumi_i = 1'b0;
        bus.data_mem_data_i     = line;
        @(negedge clk);
        check("rs_send_cmd_v", bus.lce_data_cmd_v_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_cmd_v", bus.lce_data_cmd_v_o, 1'b0);
        check("rs_tr_ready", bus.tr_ready_o, 1'b1);
        check("rs_pkt_v", bus.data_mem_pkt_v_o, 1'b0);
        bus.lce_data_cmd_ready_i = 1'b1;
        #1;
        check("rs_done", bus.tr_done_o, 1'b0);
        @(negedge clk);
        check("rs_hold_done", bus.tr_done_o, 1'b0);
        rst = 1'b0;
        bus.lce_data_cmd_ready_i = 1'b0;
        @(negedge clk);
        check("rs_after_tr_ready", bus.tr_ready_o, 1'b1);
        check("rs_after_cmd_v", bus.lce_data_cmd_v_o, 1'b0);

        // Recovery after reset.
        run_transfer(rand_req(), 1, 1, 1'b0, none);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
